// File: rtl/ddr3_app_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_app_responder_if
// Brief    : 288-bit DDR3 application port (command, write data, read return).
// Revision : 1.0
// ============================================================================
interface ddr3_app_responder_if;
  logic [2:0]   app_cmd;
  logic [31:0]  app_addr;
  logic         app_en;
  logic         app_rdy;
  logic [287:0] app_wdf_data;
  logic [35:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [287:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;

  modport master (
    output app_cmd, app_addr, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_cmd, app_addr, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface
`default_nettype wire

// File: rtl/ddr3_app_responder.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_app_responder
// Brief    : Controller-side DDR3 app responder: queues, BRAM store, fixed read latency.
// Revision : 1.0
// ============================================================================
module ddr3_app_responder #(
  parameter int BURST_AW     = 8,
  parameter int CMD_DEPTH    = 4,
  parameter int WDF_DEPTH    = 8,
  parameter int RD_LATENCY   = 4,
  parameter int STALL_PERIOD = 0
) (
  input  wire logic             clk,
  input  wire logic             Reset,
  ddr3_app_responder_if.slave   app,
  output logic [7:0]            err_count
);

  localparam int c_CMD_AW = $clog2(CMD_DEPTH);
  localparam int c_WDF_AW = $clog2(WDF_DEPTH);
  localparam int c_MEM_AW = BURST_AW + 1;
  localparam int c_CMD_W  = 3 + BURST_AW;
  localparam logic [c_CMD_AW:0] c_CMD_FULL = (c_CMD_AW+1)'(CMD_DEPTH);
  localparam logic [c_WDF_AW:0] c_WDF_FULL = (c_WDF_AW+1)'(WDF_DEPTH);
  localparam logic [c_WDF_AW:0] c_WDF_TWO  = (c_WDF_AW+1)'(2);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WR1 = 2'd1, S_RD1 = 2'd2} state_t;

  state_t r_state, w_next;
  logic   r_live, w_stall, r_wtog;
  logic   w_cmd_push, w_cmd_pop, w_wdf_push, w_wdf_pop;
  logic   w_mem_we, w_issue, w_issue_end, w_beat;
  logic   w_app_rdy, w_wdf_rdy, w_cmd_empty, w_err_cmd, w_err_end, w_unused;
  logic [8:0] w_err_sum;
  logic [7:0] r_err_count;

  logic [c_CMD_W-1:0]  r_cmd_mem [CMD_DEPTH];
  logic [c_CMD_AW-1:0] r_cmd_wp, r_cmd_rp;
  logic [c_CMD_AW:0]   r_cmd_cnt;
  logic [c_CMD_W-1:0]  w_head;
  logic [2:0]          w_head_cmd;
  logic [BURST_AW-1:0] w_head_burst;

  logic [323:0]        r_wdf_mem [WDF_DEPTH];
  logic [c_WDF_AW-1:0] r_wdf_wp, r_wdf_rp;
  logic [c_WDF_AW:0]   r_wdf_cnt;
  logic [323:0]        w_wdf_head;

  logic [287:0]          r_mem [2**c_MEM_AW];
  logic [c_MEM_AW-1:0]   w_mem_addr;
  logic [287:0]          r_dpipe [RD_LATENCY];
  logic [RD_LATENCY-1:0] r_vpipe, r_epipe;

  // Ready outputs stay low until the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (Reset) r_live <= 1'b0;
    else       r_live <= 1'b1;
  end

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      localparam int c_STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(STALL_PERIOD - 1);
      logic [c_STALL_W-1:0] r_stall_cnt;
      always_ff @(posedge clk) begin
        if (Reset || r_stall_cnt == c_STALL_LAST) r_stall_cnt <= '0;
        else                                      r_stall_cnt <= r_stall_cnt + c_STALL_W'(1);
      end
      assign w_stall = (r_stall_cnt == c_STALL_LAST);
    end else begin : g_no_stall
      assign w_stall = 1'b0;
    end
  endgenerate

  assign w_cmd_empty = (r_cmd_cnt == '0);
  assign w_app_rdy   = r_live & (r_cmd_cnt != c_CMD_FULL) & ~w_stall;
  assign w_wdf_rdy   = r_live & (r_wdf_cnt != c_WDF_FULL);
  assign w_cmd_push  = app.app_en & w_app_rdy;
  assign w_wdf_push  = app.app_wdf_wren & w_wdf_rdy;
  assign app.app_rdy     = w_app_rdy;
  assign app.app_wdf_rdy = w_wdf_rdy;

  assign w_head       = r_cmd_mem[r_cmd_rp];
  assign w_head_cmd   = w_head[c_CMD_W-1:BURST_AW];
  assign w_head_burst = w_head[BURST_AW-1:0];
  assign w_wdf_head   = r_wdf_mem[r_wdf_rp];
  assign w_mem_addr   = {w_head_burst, w_beat};
  assign w_unused     = ^{app.app_addr[31:BURST_AW+3], app.app_addr[2:0]};

  always_ff @(posedge clk) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= {app.app_cmd, app.app_addr[BURST_AW+2:3]};
    if (w_wdf_push) r_wdf_mem[r_wdf_wp] <= {app.app_wdf_mask, app.app_wdf_data};
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
      r_wdf_wp  <= '0;
      r_wdf_rp  <= '0;
      r_wdf_cnt <= '0;
      r_wtog    <= 1'b0;
    end else begin
      if (w_cmd_push) r_cmd_wp <= r_cmd_wp + c_CMD_AW'(1);
      if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + c_CMD_AW'(1);
      if (w_cmd_push && !w_cmd_pop)      r_cmd_cnt <= r_cmd_cnt + (c_CMD_AW+1)'(1);
      else if (!w_cmd_push && w_cmd_pop) r_cmd_cnt <= r_cmd_cnt - (c_CMD_AW+1)'(1);
      if (w_wdf_push) begin
        r_wdf_wp <= r_wdf_wp + c_WDF_AW'(1);
        r_wtog   <= ~r_wtog;
      end
      if (w_wdf_pop) r_wdf_rp <= r_wdf_rp + c_WDF_AW'(1);
      if (w_wdf_push && !w_wdf_pop)      r_wdf_cnt <= r_wdf_cnt + (c_WDF_AW+1)'(1);
      else if (!w_wdf_push && w_wdf_pop) r_wdf_cnt <= r_wdf_cnt - (c_WDF_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Strict in-order sequencer: a head write waiting for data blocks everything behind it.
  always_comb begin
    w_next      = r_state;
    w_cmd_pop   = 1'b0;
    w_wdf_pop   = 1'b0;
    w_mem_we    = 1'b0;
    w_issue     = 1'b0;
    w_issue_end = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_cmd_empty) begin
          case (w_head_cmd)
            3'b000: begin
              if (r_wdf_cnt >= c_WDF_TWO) begin
                w_mem_we  = 1'b1;
                w_wdf_pop = 1'b1;
                w_next    = S_WR1;
              end
            end
            3'b001: begin
              w_issue = 1'b1;
              w_next  = S_RD1;
            end
            default: w_cmd_pop = 1'b1;
          endcase
        end
      end
      S_WR1: begin
        w_mem_we  = 1'b1;
        w_wdf_pop = 1'b1;
        w_cmd_pop = 1'b1;
        w_beat    = 1'b1;
        w_next    = S_IDLE;
      end
      S_RD1: begin
        w_issue     = 1'b1;
        w_issue_end = 1'b1;
        w_beat      = 1'b1;
        w_cmd_pop   = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 36; i++) begin
        if (!w_wdf_head[288+i]) r_mem[w_mem_addr][i*8 +: 8] <= w_wdf_head[i*8 +: 8];
      end
    end
  end

  // Stage 0 of the data pipe is the RAM read register itself.
  always_ff @(posedge clk) begin
    r_dpipe[0] <= r_mem[w_mem_addr];
    for (int k = 1; k < RD_LATENCY; k++) r_dpipe[k] <= r_dpipe[k-1];
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_vpipe <= '0;
      r_epipe <= '0;
    end else begin
      r_vpipe[0] <= w_issue;
      r_epipe[0] <= w_issue_end;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_vpipe[k] <= r_vpipe[k-1];
        r_epipe[k] <= r_epipe[k-1];
      end
    end
  end

  assign app.app_rd_data_valid = r_vpipe[RD_LATENCY-1];
  assign app.app_rd_data_end   = r_epipe[RD_LATENCY-1];
  assign app.app_rd_data       = r_vpipe[RD_LATENCY-1] ? r_dpipe[RD_LATENCY-1] : '0;

  assign w_err_cmd = w_cmd_push & (app.app_cmd[2:1] != 2'b00);
  assign w_err_end = w_wdf_push & (app.app_wdf_end != r_wtog);
  assign w_err_sum = {1'b0, r_err_count} + 9'(w_err_cmd) + 9'(w_err_end);

  always_ff @(posedge clk) begin
    if (Reset)             r_err_count <= '0;
    else if (w_err_sum[8]) r_err_count <= 8'hFF;
    else                   r_err_count <= w_err_sum[7:0];
  end

  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_app_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_app_responder
// Brief    : Directed self-checking bench for ddr3_app_responder.
// Revision : 1.0
// ============================================================================
module tb_ddr3_app_responder;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] m_err, s_err;
  int cyc = 0;
  int rel = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [287:0] s_data [16];
  logic         s_end  [16];
  int s_n = 0;

  localparam logic [287:0] c_A = {72{4'hA}};
  localparam logic [287:0] c_B = {72{4'hB}};

  ddr3_app_responder_if m_if ();
  ddr3_app_responder_if s_if ();

  ddr3_app_responder #(.STALL_PERIOD(0)) dut (
    .clk(clk), .Reset(Reset), .app(m_if), .err_count(m_err)
  );
  ddr3_app_responder #(.STALL_PERIOD(3)) dut_s (
    .clk(clk), .Reset(Reset), .app(s_if), .err_count(s_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s_if.app_rd_data_valid && s_n < 16) begin
      s_data[s_n] = s_if.app_rd_data;
      s_end[s_n]  = s_if.app_rd_data_end;
      s_n++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [31:0] a, output int t);
    bit ok = 0;
    m_if.app_cmd = c; m_if.app_addr = a; m_if.app_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (m_if.app_rdy) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL cmd_timeout: app_rdy got 0 want 1"); end
    t = cyc;
    tick();
    m_if.app_en = 1'b0;
  endtask

  task automatic send_beat(input logic [287:0] d, input logic [35:0] mk, input logic e);
    bit ok = 0;
    m_if.app_wdf_data = d; m_if.app_wdf_mask = mk; m_if.app_wdf_end = e; m_if.app_wdf_wren = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (m_if.app_wdf_rdy) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL wdf_timeout: app_wdf_rdy got 0 want 1"); end
    tick();
    m_if.app_wdf_wren = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_if.app_rd_data_valid) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL rd_timeout: app_rd_data_valid got 0 want 1"); end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_tests++; if (m_if.app_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_app_rdy: got %b want 0", m_if.app_rdy); end
    n_tests++; if (m_if.app_wdf_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_wdf_rdy: got %b want 0", m_if.app_wdf_rdy); end
    n_tests++; if (m_if.app_rd_data_valid !== 1'b0 || m_if.app_rd_data_end !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_end: got %b%b want 00", m_if.app_rd_data_valid, m_if.app_rd_data_end); end
    n_tests++; if (m_if.app_rd_data !== 288'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", m_if.app_rd_data); end
    n_tests++; if (m_err !== 8'h00) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", m_err); end
    Reset = 1'b0;
    rel = cyc;
    tick();
    n_tests++; if (m_if.app_rdy !== 1'b1 || m_if.app_wdf_rdy !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_rdy: got %b%b want 11", m_if.app_rdy, m_if.app_wdf_rdy); end
  endtask

  task automatic test_write_read();
    int t;
    send_cmd(3'b000, 32'h40, t);
    send_beat(c_A, 36'h0, 1'b0);
    send_beat(c_B, 36'h0, 1'b1);
    repeat (4) tick();
    send_cmd(3'b001, 32'h40, t);
    wait_valid();
    n_tests++; if (cyc !== t + 5) begin n_fail++; $display("FAIL wr_rd_latency: got cycle %0d want %0d", cyc, t + 5); end
    n_tests++; if (m_if.app_rd_data !== c_A || m_if.app_rd_data_end !== 1'b0) begin
      n_fail++; $display("FAIL wr_rd_beat0: got %h end %b want %h end 0", m_if.app_rd_data, m_if.app_rd_data_end, c_A); end
    tick();
    n_tests++; if (m_if.app_rd_data_valid !== 1'b1 || m_if.app_rd_data !== c_B || m_if.app_rd_data_end !== 1'b1) begin
      n_fail++; $display("FAIL wr_rd_beat1: got v%b %h end %b want v1 %h end 1", m_if.app_rd_data_valid, m_if.app_rd_data, m_if.app_rd_data_end, c_B); end
    tick();
    n_tests++; if (m_if.app_rd_data_valid !== 1'b0 || m_if.app_rd_data !== 288'h0) begin
      n_fail++; $display("FAIL wr_rd_idle: got v%b %h want v0 0", m_if.app_rd_data_valid, m_if.app_rd_data); end
  endtask

  task automatic test_byte_mask();
    int t;
    logic [287:0] exp_d;
    exp_d = {{35{8'hFF}}, 8'h00};
    send_cmd(3'b000, 32'h18, t);
    send_beat({36{8'hFF}}, 36'h0, 1'b0);
    send_beat({36{8'hFF}}, 36'h0, 1'b1);
    send_cmd(3'b000, 32'h18, t);
    send_beat(288'h0, 36'hFFFFFFFFE, 1'b0);
    send_beat(288'h0, 36'hFFFFFFFFE, 1'b1);
    repeat (4) tick();
    send_cmd(3'b001, 32'h18, t);
    wait_valid();
    n_tests++; if (m_if.app_rd_data !== exp_d) begin n_fail++; $display("FAIL mask_beat0: got %h want %h", m_if.app_rd_data, exp_d); end
    tick();
    n_tests++; if (m_if.app_rd_data !== exp_d || m_if.app_rd_data_end !== 1'b1) begin
      n_fail++; $display("FAIL mask_beat1: got %h end %b want %h end 1", m_if.app_rd_data, m_if.app_rd_data_end, exp_d); end
    tick();
  endtask

  task automatic test_data_first();
    int t;
    logic exp_r;
    for (int i = 0; i < 8; i++) begin
      send_beat(288'(32'h5000_0000 + i), 36'h0, i[0]);
      exp_r = (i < 7);
      n_tests++; if (m_if.app_wdf_rdy !== exp_r) begin
        n_fail++; $display("FAIL wdf_fill_%0d: app_wdf_rdy got %b want %b", i, m_if.app_wdf_rdy, exp_r); end
    end
    repeat (2) tick();
    for (int k = 0; k < 4; k++) send_cmd(3'b000, 32'((20 + k) * 8), t);
    repeat (6) tick();
    n_tests++; if (m_if.app_wdf_rdy !== 1'b1) begin n_fail++; $display("FAIL wdf_drained: app_wdf_rdy got %b want 1", m_if.app_wdf_rdy); end
    for (int k = 0; k < 4; k += 3) begin
      send_cmd(3'b001, 32'((20 + k) * 8), t);
      wait_valid();
      n_tests++; if (m_if.app_rd_data !== 288'(32'h5000_0000 + 2 * k)) begin
        n_fail++; $display("FAIL data_first_b%0d_beat0: got %h want %h", k, m_if.app_rd_data, 288'(32'h5000_0000 + 2 * k)); end
      tick();
      n_tests++; if (m_if.app_rd_data !== 288'(32'h5000_0001 + 2 * k) || m_if.app_rd_data_end !== 1'b1) begin
        n_fail++; $display("FAIL data_first_b%0d_beat1: got %h end %b", k, m_if.app_rd_data, m_if.app_rd_data_end); end
      tick();
    end
  endtask

  task automatic test_cmd_first();
    int t;
    bit seen = 0;
    send_cmd(3'b000, 32'd240, t);
    send_cmd(3'b001, 32'd240, t);
    for (int i = 0; i < 10; i++) begin
      if (m_if.app_rd_data_valid) seen = 1;
      tick();
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cmd_first_early_valid: got 1 want 0"); end
    send_beat(288'hE0, 36'h0, 1'b0);
    send_beat(288'hE1, 36'h0, 1'b1);
    t = cyc;
    wait_valid();
    n_tests++; if (cyc !== t + 6) begin n_fail++; $display("FAIL cmd_first_latency: got cycle %0d want %0d", cyc, t + 6); end
    n_tests++; if (m_if.app_rd_data !== 288'hE0) begin n_fail++; $display("FAIL cmd_first_beat0: got %h want e0", m_if.app_rd_data); end
    tick();
    n_tests++; if (m_if.app_rd_data !== 288'hE1 || m_if.app_rd_data_end !== 1'b1) begin
      n_fail++; $display("FAIL cmd_first_beat1: got %h end %b want e1 end 1", m_if.app_rd_data, m_if.app_rd_data_end); end
    tick();
  endtask

  task automatic test_stall();
    int k, guard;
    logic exp_r;
    for (int b = 0; b < 6; b++) begin
      s_if.app_cmd = 3'b000; s_if.app_addr = 32'(b * 8); s_if.app_en = 1'b1;
      for (int i = 0; i < 10 && !s_if.app_rdy; i++) tick();
      tick();
      s_if.app_en = 1'b0;
      s_if.app_wdf_mask = 36'h0; s_if.app_wdf_wren = 1'b1;
      for (int bt = 0; bt < 2; bt++) begin
        s_if.app_wdf_data = 288'(32'h700 + 2 * b + bt);
        s_if.app_wdf_end  = bt[0];
        for (int i = 0; i < 10 && !s_if.app_wdf_rdy; i++) tick();
        tick();
      end
      s_if.app_wdf_wren = 1'b0;
    end
    repeat (4) tick();
    k = 0; guard = 0;
    s_if.app_cmd = 3'b001; s_if.app_en = 1'b1;
    while (k < 6 && guard < 100) begin
      s_if.app_addr = 32'(k * 8);
      exp_r = ((cyc - rel) % 3 != 2);
      n_tests++; if (s_if.app_rdy !== exp_r) begin
        n_fail++; $display("FAIL stall_rdy_cyc%0d: got %b want %b", cyc, s_if.app_rdy, exp_r); end
      if (s_if.app_rdy) k++;
      tick();
      guard++;
    end
    s_if.app_en = 1'b0;
    for (int i = 0; i < 100 && s_n < 12; i++) tick();
    n_tests++; if (s_n !== 12) begin n_fail++; $display("FAIL stall_beat_count: got %0d want 12", s_n); end
    for (int i = 0; i < 12; i++) begin
      n_tests++; if (s_data[i] !== 288'(32'h700 + i) || s_end[i] !== i[0]) begin
        n_fail++; $display("FAIL stall_beat_%0d: got %h end %b want %h end %b", i, s_data[i], s_end[i], 288'(32'h700 + i), i[0]); end
    end
  endtask

  task automatic test_errors_reset();
    int t;
    m_if.app_cmd = 3'b111; m_if.app_addr = 32'h0; m_if.app_en = 1'b1;
    m_if.app_wdf_data = 288'h0; m_if.app_wdf_mask = 36'h0; m_if.app_wdf_end = 1'b1; m_if.app_wdf_wren = 1'b1;
    tick();
    m_if.app_en = 1'b0; m_if.app_wdf_wren = 1'b0;
    n_tests++; if (m_err !== 8'd2) begin n_fail++; $display("FAIL err_double: got %0d want 2", m_err); end
    m_if.app_cmd = 3'b010; m_if.app_en = 1'b1;
    repeat (300) tick();
    m_if.app_en = 1'b0;
    repeat (3) tick();
    n_tests++; if (m_err !== 8'd255) begin n_fail++; $display("FAIL err_saturate: got %0d want 255", m_err); end
    send_cmd(3'b001, 32'h40, t);
    wait_valid();
    n_tests++; if (m_if.app_rd_data !== c_A) begin n_fail++; $display("FAIL pre_reset_beat0: got %h want %h", m_if.app_rd_data, c_A); end
    Reset = 1'b1;
    tick();
    n_tests++; if (m_if.app_rd_data_valid !== 1'b0 || m_if.app_rd_data !== 288'h0) begin
      n_fail++; $display("FAIL mid_burst_reset_valid: got v%b %h want v0 0", m_if.app_rd_data_valid, m_if.app_rd_data); end
    n_tests++; if (m_err !== 8'd0 || m_if.app_rdy !== 1'b0) begin
      n_fail++; $display("FAIL mid_burst_reset_state: got err %0d rdy %b want err 0 rdy 0", m_err, m_if.app_rdy); end
    Reset = 1'b0;
    repeat (2) tick();
    n_tests++; if (m_if.app_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset2_rdy: got %b want 1", m_if.app_rdy); end
    send_cmd(3'b001, 32'h40, t);
    wait_valid();
    n_tests++; if (m_if.app_rd_data !== c_A) begin n_fail++; $display("FAIL retained_beat0: got %h want %h", m_if.app_rd_data, c_A); end
    tick();
    n_tests++; if (m_if.app_rd_data !== c_B || m_if.app_rd_data_end !== 1'b1) begin
      n_fail++; $display("FAIL retained_beat1: got %h end %b want %h end 1", m_if.app_rd_data, m_if.app_rd_data_end, c_B); end
    tick();
  endtask

  initial begin
    m_if.app_cmd = 3'b000; m_if.app_addr = 32'h0; m_if.app_en = 1'b0;
    m_if.app_wdf_data = 288'h0; m_if.app_wdf_mask = 36'h0; m_if.app_wdf_wren = 1'b0; m_if.app_wdf_end = 1'b0;
    s_if.app_cmd = 3'b000; s_if.app_addr = 32'h0; s_if.app_en = 1'b0;
    s_if.app_wdf_data = 288'h0; s_if.app_wdf_mask = 36'h0; s_if.app_wdf_wren = 1'b0; s_if.app_wdf_end = 1'b0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_data_first();
    test_cmd_first();
    test_stall();
    test_errors_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
